// File: rtl/alu_pkg.sv
// ALU op encodings and helpers shared by the arbiter and its ALU core.
package alu_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_AND  = 4'b1000,
      ALU_OR   = 4'b1001,
      ALU_XOR  = 4'b1010
   } alu_op_t;

   function automatic logic alu_op_legal(alu_op_t op);
      case (op)
         ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SLL,
         ALU_SRL, ALU_SRA, ALU_AND, ALU_OR, ALU_XOR: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (a, b, op) -> (result, zero, err).
module alu_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]     a,
   input  logic [XLEN-1:0]     b,
   input  logic [ALU_OP_W-1:0] op,
   output logic [XLEN-1:0]     result,
   output logic                zero,
   output logic                err
);

   alu_op_t                 opc;
   logic signed [XLEN-1:0]  sa;
   logic signed [XLEN-1:0]  sb;
   logic        [4:0]       shamt;

   assign opc   = alu_op_t'(op);
   assign sa    = a;
   assign sb    = b;
   assign shamt = b[4:0];

   always_comb begin
      result = '0;
      err    = !alu_op_legal(opc);
      case (opc)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, (sa < sb)};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_SLL:  result = a << shamt;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = sa >>> shamt;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         default:  result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU among NREQ requesters, with a single
// registered response slot under valid/ready backpressure.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int XLEN = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*ALU_OP_W-1:0] req_op,
   input  logic [NREQ*XLEN-1:0]     req_a,
   input  logic [NREQ*XLEN-1:0]     req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [XLEN-1:0]          rsp_result,
   output logic                     rsp_zero,
   output logic                     rsp_err
);

   localparam int IDW = $clog2(NREQ);

   // Returns {found, index} of the first valid requester at or after ptr.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IDW-1:0]  ptr);
      logic [IDW:0] res;
      int           idx;
      res = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (v[idx]) res = {1'b1, IDW'(idx)};
      end
      return res;
   endfunction

   logic [IDW-1:0]      rr_ptr;
   logic [IDW-1:0]      gnt_id_p0;
   logic                gnt_found_p0;
   logic                gnt_p0;
   logic                slot_free;
   logic [ALU_OP_W-1:0] op_p0;
   logic [XLEN-1:0]     a_p0;
   logic [XLEN-1:0]     b_p0;
   logic [XLEN-1:0]     result_p0;
   logic                zero_p0;
   logic                err_p0;

   logic                vld_p1;
   logic [IDW-1:0]      id_p1;
   logic [XLEN-1:0]     result_p1;
   logic                zero_p1;
   logic                err_p1;

   // Stage p0: arbitration, operand select and ALU evaluation
   assign slot_free = !vld_p1 || rsp_ready;

   always_comb begin
      {gnt_found_p0, gnt_id_p0} = rr_pick(req_valid, rr_ptr);
      gnt_p0    = rst_n && slot_free && gnt_found_p0;
      req_ready = '0;
      if (gnt_p0) req_ready[gnt_id_p0] = 1'b1;
   end

   assign op_p0 = req_op[int'(gnt_id_p0)*ALU_OP_W +: ALU_OP_W];
   assign a_p0  = req_a[int'(gnt_id_p0)*XLEN +: XLEN];
   assign b_p0  = req_b[int'(gnt_id_p0)*XLEN +: XLEN];

   alu_core #(.XLEN(XLEN)) u_alu (
      .a      (a_p0),
      .b      (b_p0),
      .op     (op_p0),
      .result (result_p0),
      .zero   (zero_p0),
      .err    (err_p0)
   );

   // Stage p1: response slot and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         id_p1     <= '0;
         result_p1 <= '0;
         zero_p1   <= 1'b0;
         err_p1    <= 1'b0;
         rr_ptr    <= '0;
      end else if (gnt_p0) begin
         vld_p1    <= 1'b1;
         id_p1     <= gnt_id_p0;
         result_p1 <= result_p0;
         zero_p1   <= zero_p0;
         err_p1    <= err_p0;
         rr_ptr    <= IDW'((int'(gnt_id_p0) + 1) % NREQ);
      end else if (rsp_ready) begin
         vld_p1    <= 1'b0;
      end
   end

   assign rsp_valid  = vld_p1;
   assign rsp_id     = id_p1;
   assign rsp_result = result_p1;
   assign rsp_zero   = zero_p1;
   assign rsp_err    = err_p1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a
// transaction-level reference model (NREQ=2, XLEN=32).
module tb_alu_share_arbiter;

   localparam int NREQ = 2;
   localparam int XLEN = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*4-1:0]    req_op;
   logic [NREQ*XLEN-1:0] req_a;
   logic [NREQ*XLEN-1:0] req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [0:0]           rsp_id;
   logic [XLEN-1:0]      rsp_result;
   logic                 rsp_zero;
   logic                 rsp_err;

   alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Requester-side stimulus
   logic            v_in [NREQ];
   logic [3:0]      op_in[NREQ];
   logic [XLEN-1:0] a_in [NREQ];
   logic [XLEN-1:0] b_in [NREQ];

   // Reference model state
   bit              m_vld;
   int              m_id;
   logic [XLEN-1:0] m_res;
   bit              m_zero;
   bit              m_err;
   int              m_ptr;
   int              last_g;

   logic [XLEN-1:0] held;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [XLEN:0] alu_ref(input logic [3:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         4'd0:    return {1'b0, a + b};
         4'd1:    return {1'b0, a - b};
         4'd2:    return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
         4'd3:    return {1'b0, (a < b) ? 32'd1 : 32'd0};
         4'd5:    return {1'b0, a << sh};
         4'd6:    return {1'b0, a >> sh};
         4'd7:    return {1'b0, $unsigned($signed(a) >>> sh)};
         4'd8:    return {1'b0, a & b};
         4'd9:    return {1'b0, a | b};
         4'd10:   return {1'b0, a ^ b};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   task automatic model_reset();
      m_vld = 0; m_id = 0; m_res = '0; m_zero = 0; m_err = 0; m_ptr = 0;
   endtask

   task automatic pack();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]          = v_in[i];
         req_op[4*i +: 4]      = op_in[i];
         req_a[XLEN*i +: XLEN] = a_in[i];
         req_b[XLEN*i +: XLEN] = b_in[i];
      end
   endtask

   // One clock cycle: entered and left just after a falling edge.
   task automatic step();
      int g;
      logic [NREQ-1:0] exp_rdy;
      logic [XLEN:0]   r;
      pack();
      #1;
      g = -1;
      if (!m_vld || rsp_ready) begin
         for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && v_in[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      if (g >= 0) begin
         r      = alu_ref(op_in[g], a_in[g], b_in[g]);
         m_vld  = 1;
         m_id   = g;
         m_res  = r[XLEN-1:0];
         m_err  = r[XLEN];
         m_zero = (r[XLEN-1:0] == 0);
         m_ptr  = (g + 1) % NREQ;
      end else if (rsp_ready) begin
         m_vld = 0;
      end
      last_g = g;
      chk("rsp_valid",  64'(rsp_valid),  64'(m_vld));
      chk("rsp_id",     64'(rsp_id),     64'(m_id));
      chk("rsp_result", 64'(rsp_result), 64'(m_res));
      chk("rsp_zero",   64'(rsp_zero),   64'(m_zero));
      chk("rsp_err",    64'(rsp_err),    64'(m_err));
      @(negedge clk);
   endtask

   task automatic one_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      v_in[0] = 1'b1; op_in[0] = op; a_in[0] = a; b_in[0] = b;
      v_in[1] = 1'b0;
      rsp_ready = 1'b1;
      step();
      v_in[0] = 1'b0;
   endtask

   function automatic logic [XLEN-1:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         v_in[i] = 1'b0; op_in[i] = 4'd0; a_in[i] = '0; b_in[i] = '0;
      end
      pack();
      model_reset();
      last_g = -1;
      repeat (2) @(negedge clk);
      chk("rst_valid",  64'(rsp_valid),  64'd0);
      chk("rst_result", 64'(rsp_result), 64'd0);
      chk("rst_ready",  64'(req_ready),  64'd0);
      rst_n = 1'b1;

      // Single ops and signedness/shifts
      one_op(4'b0000, 32'h7FFF_FFFF, 32'h1);
      chk("add_res",  64'(rsp_result), 64'h8000_0000);
      chk("add_zero", 64'(rsp_zero),   64'd0);
      chk("add_id",   64'(rsp_id),     64'd0);
      one_op(4'b0001, 32'd5, 32'd5);
      chk("sub_res",  64'(rsp_result), 64'd0);
      chk("sub_zero", 64'(rsp_zero),   64'd1);
      one_op(4'b0010, 32'hFFFF_FFFF, 32'd1);
      chk("slt_res",  64'(rsp_result), 64'd1);
      one_op(4'b0011, 32'hFFFF_FFFF, 32'd1);
      chk("sltu_res", 64'(rsp_result), 64'd0);
      one_op(4'b0111, 32'h8000_0000, 32'h24);
      chk("sra_res",  64'(rsp_result), 64'hF800_0000);
      one_op(4'b0110, 32'h8000_0000, 32'h24);
      chk("srl_res",  64'(rsp_result), 64'h0800_0000);

      // Illegal ops, then a legal one
      one_op(4'b1100, 32'h1234, 32'h5678);
      chk("ill_err",  64'(rsp_err),    64'd1);
      chk("ill_res",  64'(rsp_result), 64'd0);
      chk("ill_zero", 64'(rsp_zero),   64'd1);
      one_op(4'b0100, 32'h1, 32'h1);
      chk("ill4_err", 64'(rsp_err),    64'd1);
      one_op(4'b0000, 32'd1, 32'd2);
      chk("legal_err", 64'(rsp_err),   64'd0);
      chk("legal_res", 64'(rsp_result), 64'd3);

      // Fairness: pointer sits at 1 after the req0-only ops above
      for (int i = 0; i < NREQ; i++) begin
         v_in[i] = 1'b1; op_in[i] = 4'd0; a_in[i] = 32'(i * 100); b_in[i] = 32'd7;
      end
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("fair_id",    64'(rsp_id),    64'((k + 1) % 2));
         chk("fair_valid", 64'(rsp_valid), 64'd1);
      end

      // Backpressure: slot full and not taken for 3 cycles
      held = rsp_result;
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_hold", 64'(rsp_result), 64'(held));
      end
      pack();
      #1;
      chk("bp_noready", 64'(req_ready), 64'd0);
      rsp_ready = 1'b1;
      step();
      chk("bp_nobubble", 64'(rsp_valid), 64'd1);

      // Asynchronous reset with a pending response
      chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(rsp_valid),  64'd0);
      chk("arst_ready", 64'(req_ready),  64'd0);
      chk("arst_res",   64'(rsp_result), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      pack();
      #1;
      chk("rst_gnt0", 64'(req_ready), 64'd1);
      step();

      // Randomized traffic; requesters hold their op until granted
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!v_in[i] || last_g == i) begin
               v_in[i]  = ($urandom_range(0, 2) != 0);
               op_in[i] = 4'($urandom_range(0, 15));
               a_in[i]  = rand_operand();
               b_in[i]  = rand_operand();
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
